// File: rtl/uart_tx_frame.sv
// UART transmit framer/serializer: start bit, DATA_BITS data bits, optional parity,
// one or two stop bits; valid/ready handshake allows back-to-back frames on the baud clock.
module uart_tx_frame #(
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int MSB_FIRST   = 0
) (
   input  logic                 baud_clk,
   input  logic                 rst_n,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 data_tx,
   output logic                 active_flag,
   output logic                 done_flag
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   localparam logic [3:0] LP_LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0] LP_LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic       LP_HAS_PAR   = (PARITY_MODE != 0);
   localparam logic       LP_ONE_STOP  = (STOP_BITS == 1);

   state_t                r_state;
   logic [DATA_BITS-1:0]  r_shift;
   logic [3:0]            r_bit_cnt;
   logic                  r_parity;
   logic                  r_tx;
   logic                  r_ready;
   logic                  r_active;
   logic                  r_done;
   logic                  w_accept;

   // The shift register always shifts right; MSB-first order is handled by reversing on load.
   function automatic logic [DATA_BITS-1:0] f_order(input logic [DATA_BITS-1:0] d);
      logic [DATA_BITS-1:0] v;
      for (int i = 0; i < DATA_BITS; i++) begin
         v[i] = (MSB_FIRST != 0) ? d[DATA_BITS-1-i] : d[i];
      end
      return v;
   endfunction

   function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
      logic p;
      p = ^d;
      return (PARITY_MODE == 2) ? ~p : p;
   endfunction

   assign w_accept    = tx_valid & r_ready;
   assign tx_ready    = r_ready;
   assign data_tx     = r_tx;
   assign active_flag = r_active;
   assign done_flag   = r_done;

   always_ff @(posedge baud_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_parity  <= 1'b0;
         r_tx      <= 1'b1;
         r_ready   <= 1'b1;
         r_active  <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            // Accepting edge: start bit goes out for the next cycle, payload is frozen here.
            r_state   <= ST_START;
            r_shift   <= f_order(tx_data);
            r_parity  <= f_parity(tx_data);
            r_bit_cnt <= '0;
            r_tx      <= 1'b0;
            r_ready   <= 1'b0;
            r_active  <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_tx     <= 1'b1;
                  r_ready  <= 1'b1;
                  r_active <= 1'b0;
               end
               ST_START: begin
                  r_state   <= ST_DATA;
                  r_tx      <= r_shift[0];
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= '0;
               end
               ST_DATA: begin
                  if (r_bit_cnt == LP_LAST_DATA) begin
                     r_bit_cnt <= '0;
                     if (LP_HAS_PAR) begin
                        r_state <= ST_PARITY;
                        r_tx    <= r_parity;
                     end else begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                        r_ready <= LP_ONE_STOP;
                        r_done  <= LP_ONE_STOP;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     r_tx      <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                  end
               end
               ST_PARITY: begin
                  r_state   <= ST_STOP;
                  r_bit_cnt <= '0;
                  r_tx      <= 1'b1;
                  r_ready   <= LP_ONE_STOP;
                  r_done    <= LP_ONE_STOP;
               end
               ST_STOP: begin
                  r_tx <= 1'b1;
                  if (r_bit_cnt == LP_LAST_STOP) begin
                     r_state   <= ST_IDLE;
                     r_bit_cnt <= '0;
                     r_ready   <= 1'b1;
                     r_active  <= 1'b0;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                     if ((r_bit_cnt + 4'd1) == LP_LAST_STOP) begin
                        r_ready <= 1'b1;
                        r_done  <= 1'b1;
                     end
                  end
               end
               default: begin
                  r_state   <= ST_IDLE;
                  r_bit_cnt <= '0;
                  r_tx      <= 1'b1;
                  r_ready   <= 1'b1;
                  r_active  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three parameter sets, scoreboard of expected per-cycle line/flag values.
module tb_uart_tx_frame;

   typedef struct packed {
      logic tx;
      logic rdy;
      logic dn;
      logic act;
   } exp_t;

   logic       baud_clk = 1'b0;
   logic       rst_n    = 1'b1;
   logic       vld_a = 1'b0, vld_b = 1'b0, vld_c = 1'b0;
   logic [7:0] dat_a = '0, dat_b = '0;
   logic [4:0] dat_c = '0;
   logic       tx_a, rdy_a, act_a, dn_a;
   logic       tx_b, rdy_b, act_b, dn_b;
   logic       tx_c, rdy_c, act_c, dn_c;

   exp_t       sb[$];
   int         checks   = 0;
   int         failures = 0;

   always #5 baud_clk = ~baud_clk;

   uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .MSB_FIRST(0)) dut_a (
      .baud_clk(baud_clk), .rst_n(rst_n), .tx_valid(vld_a), .tx_data(dat_a),
      .tx_ready(rdy_a), .data_tx(tx_a), .active_flag(act_a), .done_flag(dn_a));

   uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .MSB_FIRST(1)) dut_b (
      .baud_clk(baud_clk), .rst_n(rst_n), .tx_valid(vld_b), .tx_data(dat_b),
      .tx_ready(rdy_b), .data_tx(tx_b), .active_flag(act_b), .done_flag(dn_b));

   uart_tx_frame #(.DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2), .MSB_FIRST(0)) dut_c (
      .baud_clk(baud_clk), .rst_n(rst_n), .tx_valid(vld_c), .tx_data(dat_c),
      .tx_ready(rdy_c), .data_tx(tx_c), .active_flag(act_c), .done_flag(dn_c));

   function automatic exp_t sample(input int sel);
      exp_t o;
      case (sel)
         0:       o = '{tx: tx_a, rdy: rdy_a, dn: dn_a, act: act_a};
         1:       o = '{tx: tx_b, rdy: rdy_b, dn: dn_b, act: act_b};
         default: o = '{tx: tx_c, rdy: rdy_c, dn: dn_c, act: act_c};
      endcase
      return o;
   endfunction

   task automatic drive(input int sel, input logic v, input logic [8:0] d);
      case (sel)
         0:       begin vld_a = v; dat_a = d[7:0]; end
         1:       begin vld_b = v; dat_b = d[7:0]; end
         default: begin vld_c = v; dat_c = d[4:0]; end
      endcase
   endtask

   // Reference frame: start 0, data bits in chosen order, optional parity, stop bits;
   // ready and done only in the final stop cycle, active throughout.
   task automatic push_frame(input int nb, input int pm, input int ns, input int msb,
                             input logic [8:0] d);
      logic p;
      p = 1'b0;
      sb.push_back('{tx: 1'b0, rdy: 1'b0, dn: 1'b0, act: 1'b1});
      for (int i = 0; i < nb; i++) begin
         p = p ^ d[i];
         sb.push_back('{tx: (msb != 0) ? d[nb-1-i] : d[i], rdy: 1'b0, dn: 1'b0, act: 1'b1});
      end
      if (pm != 0)
         sb.push_back('{tx: (pm == 2) ? ~p : p, rdy: 1'b0, dn: 1'b0, act: 1'b1});
      for (int s = 1; s <= ns; s++)
         sb.push_back('{tx: 1'b1, rdy: (s == ns), dn: (s == ns), act: 1'b1});
   endtask

   task automatic chk(input string tag, input exp_t o, input exp_t e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed(tx,rdy,dn,act)=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic step(input int sel, input string tag);
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL %s observed=no-entry expected=scoreboard-entry", tag);
      end else begin
         chk(tag, sample(sel), sb.pop_front());
      end
   endtask

   task automatic idle_chk(input int sel, input string tag);
      chk(tag, sample(sel), '{tx: 1'b1, rdy: 1'b1, dn: 1'b0, act: 1'b0});
   endtask

   task automatic send(input int sel, input logic [8:0] d, input int nb, input int pm,
                       input int ns, input int msb, input string tag);
      int f;
      f = 1 + nb + ((pm != 0) ? 1 : 0) + ns;
      drive(sel, 1'b1, d);
      push_frame(nb, pm, ns, msb, d);
      for (int i = 1; i <= f; i++) begin
         @(negedge baud_clk);
         step(sel, tag);
         if (i == 1) drive(sel, 1'b0, ~d);
      end
      @(negedge baud_clk);
      idle_chk(sel, {tag, "_idle"});
   endtask

   initial begin
      // Reset and idle
      #2 rst_n = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) idle_chk(s, "reset_async");
      @(negedge baud_clk);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge baud_clk);
         for (int s = 0; s < 3; s++) idle_chk(s, "idle_after_reset");
      end

      send(0, 9'h0A5, 8, 1, 1, 0, "a5_even");
      send(1, 9'h001, 8, 2, 1, 1, "01_odd_msb");
      send(2, 9'h013, 5, 0, 2, 0, "13_5b_2stop");
      send(2, 9'h00E, 5, 0, 2, 0, "0e_5b_2stop");
      send(1, 9'h0B4, 8, 2, 1, 1, "b4_odd_msb");

      // Back-to-back with tx_data churning mid-frame
      drive(0, 1'b1, 9'h055);
      push_frame(8, 1, 1, 0, 9'h055);
      push_frame(8, 1, 1, 0, 9'h00F);
      for (int i = 1; i <= 22; i++) begin
         @(negedge baud_clk);
         step(0, "b2b");
         if (i == 11)      drive(0, 1'b1, 9'h00F);
         else if (i == 22) drive(0, 1'b0, 9'h000);
         else if (i < 11)  drive(0, 1'b1, 9'(8'hFF ^ i));
         else              drive(0, 1'b1, 9'h0C3);
      end
      @(negedge baud_clk);
      idle_chk(0, "b2b_idle");

      // Reset in cycle 4 of a frame
      drive(0, 1'b1, 9'h0A5);
      push_frame(8, 1, 1, 0, 9'h0A5);
      for (int i = 1; i <= 4; i++) begin
         @(negedge baud_clk);
         step(0, "midrst_pre");
         if (i == 1) drive(0, 1'b0, 9'h000);
      end
      #2 rst_n = 1'b0;
      #1 idle_chk(0, "midrst_async");
      sb.delete();
      @(negedge baud_clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge baud_clk);
         idle_chk(0, "midrst_idle");
      end
      send(0, 9'h03C, 8, 1, 1, 0, "post_rst_3c");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
